// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU retire/writeback stage.
package alu_wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_REG_AW = 3;

  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [2:0]           flags;
    logic [WB_REG_AW-1:0] rd;
    logic                 wb;
    logic                 setf;
  } entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Two-entry FIFO holding retired ALU results ahead of the register-file write.
module alu_wb_fifo
  import alu_wb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t push_entry,
  output logic   full,
  output logic   empty,
  output entry_t head,
  output logic   second_wb
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       wr_ptr;

  // Write slot sits one past the head when a single entry is present.
  assign wr_ptr = rd_ptr_q ^ count_q[0];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) mem_d[wr_ptr] = push_entry;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign head      = mem_q[rd_ptr_q];
  assign second_wb = mem_q[~rd_ptr_q].wb;

endmodule

// File: rtl/alu_writeback.sv
// ALU retire stage: queues results, arbitrates for the RF write port, commits C/status.
// Build option: define ALU_WB_STICKY_OVF_EN for a sticky V flag cleared by clr_ovf.
//
// state     | meaning
// ST_IDLE   | queue empty, nothing to retire
// ST_ARB    | head needs RF write, rf_req held until rf_gnt
// ST_COMMIT | head retires this cycle (rf_we if wb), popped at edge
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_flags,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wb,
  input  logic              in_setf,
  output logic              rf_req,
  input  logic              rf_gnt,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] c_out,
  output logic [2:0]        status_out,
  input  logic              clr_ovf,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [2:0]        status_q, status_d;

  logic   push, pop, full, empty, second_wb;
  logic   nxt_avail, nxt_wb, commit_flags;
  entry_t in_entry, head;

  assign in_entry = '{data: in_data, flags: in_flags, rd: in_rd, wb: in_wb, setf: in_setf};
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign pop      = (state_q == ST_COMMIT);

  alu_wb_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .push_entry (in_entry),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .second_wb  (second_wb)
  );

  // Next state is chosen from the queue as it will look after this edge,
  // so a fresh push reaches ARB/COMMIT without an extra IDLE cycle.
  always_comb begin
    if (pop) begin
      nxt_avail = full | push;
      nxt_wb    = full ? second_wb : in_wb;
    end else begin
      nxt_avail = ~empty | push;
      nxt_wb    = empty ? in_wb : head.wb;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (nxt_avail) state_d = nxt_wb ? ST_ARB : ST_COMMIT;
      ST_ARB:    if (rf_gnt) state_d = ST_COMMIT;
      ST_COMMIT: state_d = nxt_avail ? (nxt_wb ? ST_ARB : ST_COMMIT) : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    commit_flags = (state_q == ST_COMMIT) & head.setf;
    c_d          = (state_q == ST_COMMIT) ? head.data : c_q;
    status_d     = status_q;
    if (commit_flags) begin
      status_d[FLAG_Z] = head.flags[FLAG_Z];
      status_d[FLAG_N] = head.flags[FLAG_N];
    end
`ifdef ALU_WB_STICKY_OVF_EN
    status_d[FLAG_V] = (status_q[FLAG_V] & ~clr_ovf) | (commit_flags & head.flags[FLAG_V]);
`else
    if (commit_flags) status_d[FLAG_V] = head.flags[FLAG_V];
`endif
  end

`ifndef ALU_WB_STICKY_OVF_EN
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      c_q      <= '0;
      status_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign rf_req     = (state_q == ST_ARB);
  assign rf_we      = (state_q == ST_COMMIT) & head.wb;
  assign rf_waddr   = rf_we ? head.rd : '0;
  assign rf_wdata   = rf_we ? head.data : '0;
  assign c_out      = c_q;
  assign status_out = status_q;
  assign busy       = ~empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with a write-port scoreboard.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_flags;
  logic [2:0]  in_rd;
  logic        in_wb, in_setf;
  logic        rf_req, rf_gnt, rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] c_out;
  logic [2:0]  status_out;
  logic        clr_ovf, busy;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;

`ifdef ALU_WB_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_flags   (in_flags),
    .in_rd      (in_rd),
    .in_wb      (in_wb),
    .in_setf    (in_setf),
    .rf_req     (rf_req),
    .rf_gnt     (rf_gnt),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .c_out      (c_out),
    .status_out (status_out),
    .clr_ovf    (clr_ovf),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [2:0] f, input logic [2:0] rd,
                       input logic wb, input logic setf);
    in_valid = 1'b1;
    in_data  = d;
    in_flags = f;
    in_rd    = rd;
    in_wb    = wb;
    in_setf  = setf;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic sb_push(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rf_we === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_we", {31'd0, rf_we}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("wb_addr", {29'd0, rf_waddr}, {29'd0, e.a});
        chk("wb_data", {16'd0, rf_wdata}, {16'd0, e.d});
      end
    end else begin
      chk("wr_zero_when_idle", {13'd0, rf_waddr, rf_wdata}, 32'd0);
    end
  end

  initial begin
    bit acc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_flags = '0;
    in_rd    = '0;
    in_wb    = 1'b0;
    in_setf  = 1'b0;
    rf_gnt   = 1'b0;
    clr_ovf  = 1'b0;
    step();
    step();

    // reset values
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_rf_req", {31'd0, rf_req}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_c_out", {16'd0, c_out}, 32'd0);
    chk("rst_status", {29'd0, status_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // single wb entry with grant tied high
    rf_gnt = 1'b1;
    drive(16'h00FF, 3'b000, 3'd3, 1'b1, 1'b1);
    sb_push(3'd3, 16'h00FF);
    step();
    idle_in();
    chk("t1_req_n1", {31'd0, rf_req}, 32'd1);
    chk("t1_we_n1", {31'd0, rf_we}, 32'd0);
    chk("t1_busy_n1", {31'd0, busy}, 32'd1);
    step();
    chk("t1_we_n2", {31'd0, rf_we}, 32'd1);
    chk("t1_req_n2", {31'd0, rf_req}, 32'd0);
    step();
    chk("t1_c_out", {16'd0, c_out}, 32'h00FF);
    chk("t1_status", {29'd0, status_out}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // stalled grant, queue fills, third push blocked
    rf_gnt = 1'b0;
    drive(16'h1111, 3'b000, 3'd1, 1'b1, 1'b0);
    chk("t2_ready_a", {31'd0, in_ready}, 32'd1);
    sb_push(3'd1, 16'h1111);
    step();
    drive(16'h2222, 3'b000, 3'd2, 1'b1, 1'b0);
    chk("t2_ready_b", {31'd0, in_ready}, 32'd1);
    sb_push(3'd2, 16'h2222);
    step();
    drive(16'h4444, 3'b000, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_ready_full", {31'd0, in_ready}, 32'd0);
      chk("t2_req_held", {31'd0, rf_req}, 32'd1);
      step();
    end
    rf_gnt = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) begin
        sb_push(3'd4, 16'h4444);
        step();
        idle_in();
        acc = 1'b1;
        break;
      end
      step();
    end
    idle_in();
    chk("t2_c_accepted", {31'd0, acc}, 32'd1);
    wait_idle("t2_drain");
    chk("t2_c_out", {16'd0, c_out}, 32'h4444);
    chk("t2_sb_empty", sb.size(), 32'd0);

    // wb=0 entries update C/status only; grant high but ignored
    drive(16'h0000, 3'b100, 3'd6, 1'b0, 1'b1);
    step();
    idle_in();
    chk("t3_no_we", {31'd0, rf_we}, 32'd0);
    chk("t3_no_req", {31'd0, rf_req}, 32'd0);
    step();
    chk("t3_c_out", {16'd0, c_out}, 32'd0);
    chk("t3_status", {29'd0, status_out}, 32'd4);
    drive(16'h1234, 3'b011, 3'd7, 1'b0, 1'b0);
    step();
    idle_in();
    step();
    chk("t3_c_out2", {16'd0, c_out}, 32'h1234);
    chk("t3_status_kept", {29'd0, status_out}, 32'd4);

    // back-to-back wb=0: one commit per cycle
    drive(16'h0011, 3'b000, 3'd0, 1'b0, 1'b0);
    step();
    drive(16'h0022, 3'b000, 3'd0, 1'b0, 1'b0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    step();
    idle_in();
    chk("t6_c_first", {16'd0, c_out}, 32'h0011);
    step();
    chk("t6_c_second", {16'd0, c_out}, 32'h0022);
    chk("t6_busy", {31'd0, busy}, 32'd0);

    // reset while arbitrating
    rf_gnt = 1'b0;
    drive(16'hBEEF, 3'b000, 3'd5, 1'b1, 1'b1);
    step();
    idle_in();
    chk("t4_req_arb", {31'd0, rf_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_req_drop", {31'd0, rf_req}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_c_out", {16'd0, c_out}, 32'd0);
    chk("t4_status", {29'd0, status_out}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    rf_gnt = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t4_req_after", {31'd0, rf_req}, 32'd0);
    chk("t4_busy_after", {31'd0, busy}, 32'd0);
    chk("t4_c_after", {16'd0, c_out}, 32'd0);

    // overflow flag behaviour
    drive(16'h0001, 3'b001, 3'd0, 1'b0, 1'b1);
    step();
    idle_in();
    step();
    chk("t5_v_set", {29'd0, status_out}, 32'd1);
    drive(16'h0002, 3'b000, 3'd0, 1'b0, 1'b1);
    step();
    idle_in();
    step();
    chk("t5_v_second", {29'd0, status_out}, STICKY ? 32'd1 : 32'd0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t5_v_clr", {29'd0, status_out}, 32'd0);
    drive(16'h0003, 3'b001, 3'd0, 1'b0, 1'b1);
    step();
    idle_in();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t5_set_wins", {29'd0, status_out}, 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("t5_clr_only", {29'd0, status_out}, STICKY ? 32'd0 : 32'd1);

    step();
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Retire stage directly downstream of the 16-bit ALU. Buffers each ALU result with its {Z,N,V} flags in a 2-entry queue, arbitrates for the shared register-file write port, and commits the result to the destination register. Holds the architectural result register C and the status register consumed by branch logic. Frees the ALU to issue while a register-file write is stalled.

## Interface
- DATA_W, 16: result width
- REG_AW, 3: register-file address width (8 registers)
- clk  in  1  rising-edge clock; only clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept; equals queue-not-full
- in_data  in  DATA_W  ALU result
- in_flags  in  3  {Z,N,V} from ALU, bit2=Z, bit1=N, bit0=V
- in_rd  in  REG_AW  destination register
- in_wb  in  1  1 = write in_data to in_rd
- in_setf  in  1  1 = update status from in_flags
- rf_req  out  1  request for register-file write port
- rf_gnt  in  1  grant; sampled only while rf_req=1
- rf_we  out  1  write strobe, one cycle per committed write
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- c_out  out  DATA_W  result register C
- status_out  out  3  status register {Z,N,V}
- clr_ovf  in  1  clear sticky overflow (see Configuration)
- busy  out  1  queue non-empty or FSM not IDLE

## Operation
- Push: in_valid && in_ready at a clock edge enqueues {data, flags, rd, wb, setf}. in_valid with in_ready=0: not accepted; upstream holds.
- Queue: 2 entries, FIFO order. Push and pop in the same cycle allowed at any occupancy except push when full (blocked by in_ready).
- FSM on queue head:
  - IDLE: queue empty -> stay. Head with wb=1 -> ARB. Head with wb=0 -> COMMIT.
  - ARB: rf_req=1. rf_gnt=1 -> COMMIT; else stay. rf_req never retracted before grant.
  - COMMIT: rf_we=rf_req... rf_we=head.wb, rf_waddr=head.rd, rf_wdata=head.data; C <= head.data; if head.setf, status <= head.flags; pop head. Next: IDLE if queue then empty, else ARB/COMMIT per new head's wb.
- rf_waddr/rf_wdata are 0 whenever rf_we=0.
- rf_gnt outside ARB is ignored.
- Reset mid-operation: queue flushed, FSM IDLE, no write issued; partial commits impossible.

## Timing
- Reset values: in_ready=1, rf_req=0, rf_we=0, rf_waddr=0, rf_wdata=0, c_out=0, status_out=3'b000, busy=0.
- wb=1, push at edge N, rf_gnt high immediately: rf_req high in cycle N+1, rf_we high in N+2, c_out/status_out updated at edge ending N+2.
- wb=0: COMMIT in N+1, c_out/status visible after that edge; rf_we stays 0.
- Each entry occupies COMMIT exactly one cycle; sustained throughput one entry per 2 cycles for wb entries, one per cycle for wb=0.
- in_ready combinational from registered occupancy only (no path from rf_gnt).

## Configuration
- ALU_WB_STICKY_OVF_EN defined: status V is sticky; on commit with setf, V <= V | head.V. clr_ovf=1 clears V at next edge; if same cycle sets V, set wins. Z, N overwrite normally.
- Undefined: V overwritten like Z, N; clr_ovf ignored.

## Structure
- Package alu_wb_pkg: state enum (IDLE, ARB, COMMIT), flag index constants FLAG_Z=2, FLAG_N=1, FLAG_V=0, queue entry struct.
- Sub-module alu_wb_fifo: 2-entry queue with push/pop/full/empty and head outputs.

## Test plan
- Reset then push {data=16'h00FF, flags=3'b000, rd=3, wb=1, setf=1}, rf_gnt tied 1 -> rf_req N+1, rf_we N+2 with waddr=3, wdata=16'h00FF; c_out=16'h00FF, status=000.
- Hold rf_gnt=0 for 5 cycles, push 3 wb entries -> third push blocked (in_ready=0 after two), rf_req held high; release grant -> writes in push order.
- Push wb=0, setf=1, data=0, flags=3'b100 -> no rf_we, c_out=0, status=100; next setf=0 entry leaves status 100.
- Assert rst_n=0 during ARB -> rf_req drops immediately, no rf_we afterward, busy=0, c_out=0.
- With ALU_WB_STICKY_OVF_EN: commit V=1 then V=0 (setf) -> status V stays 1; clr_ovf pulse -> V=0; clr_ovf same cycle as V=1 commit -> V=1. Without macro: second commit gives V=0.
